datapath_sequencer: RTL and testbench

- Multi-cycle command sequencer that drives the control word of the LEGv8 datapath (register file, ALU and D-bus tristates).
- Accepts one register-level operation per valid/ready handshake and issues the required SA/SB/DA/FS/Cin/selbork/W/tristate sequence.
- Latches the ALU status and signals completion.
- Sits between an upstream command source (test driver or future instruction decoder) and the datapath.

---
 rtl/datapath_sequencer_if.sv | 67 ++++++
 rtl/datapath_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// ---------------------------------------------------------------------------
// datapath_sequencer_if
//   Bundle between a command source, the datapath_sequencer and the LEGv8
//   datapath (register file, ALU, D-bus tristates).
//
//   Command handshake: a command transfers on a rising clock edge where
//   cmd_valid and cmd_ready are both 1. The source holds cmd_* stable while
//   cmd_valid is high; cmd_ready does not depend on cmd_valid.
//
//   Signals
//     cmd_valid, cmd_op[3:0], cmd_rd/rn/rm[4:0], cmd_imm[63:0], cmd_shamt[5:0]
//                                            command from source
//     cmd_ready                              sequencer can accept a command
//     SA, SB, DA[4:0], FS[4:0], Cin, selbork, k[63:0], W,
//     triSelBtoD, triSelFtoD                 datapath control word
//     status[3:0]                            ALU status from datapath
//     flags[3:0], busy, done, err            sequencer status
//     state_dbg[1:0]                         FSM state (0 IDLE, 1 EXEC, 2 DONE)
//
//   Modports
//     slave  : the sequencer
//     master : the environment (command source plus datapath)
// ---------------------------------------------------------------------------
interface datapath_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rn;
    logic [4:0]  cmd_rm;
    logic [63:0] cmd_imm;
    logic [5:0]  cmd_shamt;

    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  DA;
    logic [4:0]  FS;
    logic        Cin;
    logic        selbork;
    logic [63:0] k;
    logic        W;
    logic        triSelBtoD;
    logic        triSelFtoD;

    logic [3:0]  status;
    logic [3:0]  flags;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_shamt,
        input  status,
        output cmd_ready,
        output SA, SB, DA, FS, Cin, selbork, k, W, triSelBtoD, triSelFtoD,
        output flags, busy, done, err, state_dbg
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_shamt,
        output status,
        input  cmd_ready,
        input  SA, SB, DA, FS, Cin, selbork, k, W, triSelBtoD, triSelFtoD,
        input  flags, busy, done, err, state_dbg
    );
endinterface

// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
//   Multi-cycle sequencer driving the LEGv8 datapath control word. Accepts one
//   register-level command per handshake, runs it through IDLE -> EXEC -> DONE,
//   latches the ALU status of the last EXEC cycle into flags and pulses done
//   (with err for an illegal op).
//
//   Ports
//     clock  : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : datapath_sequencer_if.slave (command handshake, control word,
//              ALU status, flags/busy/done/err, state_dbg)
//
//   Ops: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 ADDI, 6 SUBI, 7 MOV, 8 LSL,
//        9 CMP (only when DATAPATH_SEQ_CMP_EN is defined), others illegal.
//
//   Build option
//     DATAPATH_SEQ_CMP_EN : makes op 9 (CMP) legal; otherwise it is illegal.
// ---------------------------------------------------------------------------
module datapath_sequencer #(
    parameter logic [4:0] FS_ADD = 5'b01000,
    parameter logic [4:0] FS_SUB = 5'b01010,
    parameter logic [4:0] FS_AND = 5'b00000,
    parameter logic [4:0] FS_ORR = 5'b00100,
    parameter logic [4:0] FS_EOR = 5'b01100
) (
    input  logic                 clock,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic [4:0]  r_rn;
    logic [4:0]  r_rm;
    logic [63:0] r_imm;
    logic [5:0]  r_cnt;       // EXEC cycles still to run, including the current one
    logic        r_first;     // current EXEC cycle is the first of this command
    logic        r_illegal;
    logic        r_mov_path;  // MOV, or LSL with a zero shift amount
    logic [3:0]  r_flags;

    logic        w_accept;
    logic        w_legal;
    logic        w_last;
    logic        w_wr_ok;
    logic [4:0]  w_src;

    logic [4:0]  w_sa, w_sb, w_da, w_fs;
    logic        w_cin, w_selbork, w_w, w_tri_b, w_tri_f;
    logic [63:0] w_k;

    assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt <= 6'd1);
    // X31 is XZR: the operation still runs, only the write is suppressed.
    assign w_wr_ok  = (r_rd != 5'd31);
    // LSL doubles rn into rd first, then keeps doubling rd in place.
    assign w_src    = r_first ? r_rn : r_rd;

    always_comb begin
        w_legal = (bus.cmd_op <= 4'd8);
`ifdef DATAPATH_SEQ_CMP_EN
        if (bus.cmd_op == 4'd9) begin
            w_legal = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_legal ? ST_EXEC : ST_DONE;
            ST_EXEC: if (w_last)   w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Command registers, iteration counter and flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op       <= '0;
            r_rd       <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_imm      <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_illegal  <= 1'b0;
            r_mov_path <= 1'b0;
            r_flags    <= '0;
        end else if (w_accept) begin
            r_op       <= bus.cmd_op;
            r_rd       <= bus.cmd_rd;
            r_rn       <= bus.cmd_rn;
            r_rm       <= bus.cmd_rm;
            r_imm      <= bus.cmd_imm;
            r_cnt      <= (bus.cmd_op == 4'd8 && bus.cmd_shamt != 6'd0) ? bus.cmd_shamt : 6'd1;
            r_first    <= 1'b1;
            r_illegal  <= !w_legal;
            r_mov_path <= (bus.cmd_op == 4'd7) || (bus.cmd_op == 4'd8 && bus.cmd_shamt == 6'd0);
        end else if (r_state == ST_EXEC) begin
            r_first <= 1'b0;
            if (w_last) begin
                r_flags <= bus.status;
            end else begin
                r_cnt <= r_cnt - 6'd1;
            end
        end
    end

    // Output logic: control word is a function of registered state only,
    // so it is stable across each EXEC cycle and zero elsewhere.
    always_comb begin
        w_sa      = '0;
        w_sb      = '0;
        w_da      = '0;
        w_fs      = '0;
        w_cin     = 1'b0;
        w_selbork = 1'b0;
        w_k       = '0;
        w_w       = 1'b0;
        w_tri_b   = 1'b0;
        w_tri_f   = 1'b0;
        if (r_state == ST_EXEC) begin
            if (r_mov_path) begin
                // ORR with XZR passes rn through the ALU so flags reflect rn,
                // while the value reaches D through the B-bus driver.
                w_sa    = 5'd31;
                w_sb    = r_rn;
                w_da    = r_rd;
                w_fs    = FS_ORR;
                w_tri_b = 1'b1;
                w_w     = w_wr_ok;
            end else begin
                case (r_op)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                        w_sa    = r_rn;
                        w_sb    = r_rm;
                        w_da    = r_rd;
                        w_cin   = (r_op == 4'd1);
                        w_tri_f = 1'b1;
                        w_w     = w_wr_ok;
                        case (r_op)
                            4'd0:    w_fs = FS_ADD;
                            4'd1:    w_fs = FS_SUB;
                            4'd2:    w_fs = FS_AND;
                            4'd3:    w_fs = FS_ORR;
                            default: w_fs = FS_EOR;
                        endcase
                    end
                    4'd5, 4'd6: begin
                        w_sa      = r_rn;
                        w_sb      = r_rm;
                        w_da      = r_rd;
                        w_fs      = (r_op == 4'd6) ? FS_SUB : FS_ADD;
                        w_cin     = (r_op == 4'd6);
                        w_selbork = 1'b1;
                        w_k       = r_imm;
                        w_tri_f   = 1'b1;
                        w_w       = w_wr_ok;
                    end
                    4'd8: begin
                        w_sa    = w_src;
                        w_sb    = w_src;
                        w_da    = r_rd;
                        w_fs    = FS_ADD;
                        w_tri_f = 1'b1;
                        w_w     = w_wr_ok;
                    end
`ifdef DATAPATH_SEQ_CMP_EN
                    4'd9: begin
                        // Compare: subtract for flags only, nothing drives D.
                        w_sa  = r_rn;
                        w_sb  = r_rm;
                        w_da  = r_rd;
                        w_fs  = FS_SUB;
                        w_cin = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.SA         = w_sa;
    assign bus.SB         = w_sb;
    assign bus.DA         = w_da;
    assign bus.FS         = w_fs;
    assign bus.Cin        = w_cin;
    assign bus.selbork    = w_selbork;
    assign bus.k          = w_k;
    assign bus.W          = w_w;
    assign bus.triSelBtoD = w_tri_b;
    assign bus.triSelFtoD = w_tri_f;
    assign bus.flags      = r_flags;
    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = (r_state == ST_DONE) && r_illegal;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// ---------------------------------------------------------------------------
// tb_datapath_sequencer
//   Bench for datapath_sequencer: a behavioural register file + ALU answers
//   the control word, a reference model turns each command into the list of
//   expected EXEC control words and the expected completion, and a monitor
//   compares whatever the sequencer presents.
//   Status bit order used by the datapath model: {V, C, N, Z}.
// ---------------------------------------------------------------------------
module tb_datapath_sequencer;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam int CW = 89;

    // ------------------------------------------------------------ clock/reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    datapath_sequencer_if bus();

    datapath_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------ datapath model
    function automatic logic [67:0] alu(input logic [4:0] fs, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin);
        logic [64:0] sum;
        logic [63:0] bb;
        logic [63:0] f;
        logic        c;
        logic        v;
        bb  = (fs == FS_SUB) ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
        c   = 1'b0;
        v   = 1'b0;
        case (fs)
            FS_ADD, FS_SUB: begin
                f = sum[63:0];
                c = sum[64];
                v = (a[63] == bb[63]) && (f[63] != a[63]);
            end
            FS_AND:  f = a & b;
            FS_ORR:  f = a | b;
            FS_EOR:  f = a ^ b;
            default: f = '0;
        endcase
        return {v, c, f[63], (f == 64'd0), f};
    endfunction

    logic [63:0] xreg [32];
    logic [63:0] ra, rb, bsel, alu_f;
    logic [3:0]  alu_st;
    int          wr_cnt = 0;

    always_comb begin
        ra   = (bus.SA == 5'd31) ? 64'd0 : xreg[bus.SA];
        rb   = (bus.SB == 5'd31) ? 64'd0 : xreg[bus.SB];
        bsel = bus.selbork ? bus.k : rb;
        {alu_st, alu_f} = alu(bus.FS, ra, bsel, bus.Cin);
    end
    assign bus.status = alu_st;

    always @(posedge clock) begin
        if (bus.W) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.DA != 5'd31) xreg[bus.DA] <= bus.triSelFtoD ? alu_f : rb;
        end
    end

    // ------------------------------------------------------------ scoreboard
    logic [CW-1:0] exp_q[$];   // one control word per expected EXEC cycle
    logic [12:0]   done_q[$];  // {latency[7:0], err, flags[3:0]}
    logic [63:0]   m_x [32];
    logic [3:0]    m_flags = 4'd0;
    int            checks = 0;
    int            errors = 0;
    int            acc_cyc = 0;
    bit            mon_en = 1'b0;

    logic [CW-1:0] dut_cw;
    assign dut_cw = {bus.SA, bus.SB, bus.DA, bus.FS, bus.Cin, bus.selbork, bus.k,
                     bus.W, bus.triSelBtoD, bus.triSelFtoD};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] cw(input logic [4:0] sa, input logic [4:0] sb,
                                         input logic [4:0] da, input logic [4:0] fs,
                                         input logic cin, input logic sel, input logic [63:0] kk,
                                         input logic w, input logic tb, input logic tf);
        return {sa, sb, da, fs, cin, sel, kk, w, tb, tf};
    endfunction

    function automatic logic [63:0] mreg(input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : m_x[r];
    endfunction

    // Reference model: architectural effect of one command.
    task automatic model_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                             input logic [4:0] rm, input logic [63:0] imm, input logic [5:0] sh);
        logic [67:0] o;
        logic [63:0] cur;
        logic [4:0]  fs;
        logic [4:0]  src;
        logic        w;
        w = (rd != 5'd31);
        if (op <= 4'd4) begin
            case (op)
                4'd0:    fs = FS_ADD;
                4'd1:    fs = FS_SUB;
                4'd2:    fs = FS_AND;
                4'd3:    fs = FS_ORR;
                default: fs = FS_EOR;
            endcase
            o = alu(fs, mreg(rn), mreg(rm), op == 4'd1);
            exp_q.push_back(cw(rn, rm, rd, fs, op == 4'd1, 1'b0, 64'd0, w, 1'b0, 1'b1));
            if (w) m_x[rd] = o[63:0];
            m_flags = o[67:64];
            done_q.push_back({8'd1, 1'b0, m_flags});
        end else if (op == 4'd5 || op == 4'd6) begin
            fs = (op == 4'd6) ? FS_SUB : FS_ADD;
            o  = alu(fs, mreg(rn), imm, op == 4'd6);
            exp_q.push_back(cw(rn, rm, rd, fs, op == 4'd6, 1'b1, imm, w, 1'b0, 1'b1));
            if (w) m_x[rd] = o[63:0];
            m_flags = o[67:64];
            done_q.push_back({8'd1, 1'b0, m_flags});
        end else if (op == 4'd7 || (op == 4'd8 && sh == 6'd0)) begin
            o = alu(FS_ORR, 64'd0, mreg(rn), 1'b0);
            exp_q.push_back(cw(5'd31, rn, rd, FS_ORR, 1'b0, 1'b0, 64'd0, w, 1'b1, 1'b0));
            if (w) m_x[rd] = mreg(rn);
            m_flags = o[67:64];
            done_q.push_back({8'd1, 1'b0, m_flags});
        end else if (op == 4'd8) begin
            // Shift by repeated doubling; later passes read rd (zero when rd is XZR).
            cur = mreg(rn);
            for (int i = 1; i <= int'(sh); i++) begin
                src = (i == 1) ? rn : rd;
                exp_q.push_back(cw(src, src, rd, FS_ADD, 1'b0, 1'b0, 64'd0, w, 1'b0, 1'b1));
                if (i > 1 && !w) cur = 64'd0;
                o   = alu(FS_ADD, cur, cur, 1'b0);
                cur = o[63:0];
                m_flags = o[67:64];
            end
            if (w) m_x[rd] = cur;
            done_q.push_back({8'(sh), 1'b0, m_flags});
`ifdef DATAPATH_SEQ_CMP_EN
        end else if (op == 4'd9) begin
            o = alu(FS_SUB, mreg(rn), mreg(rm), 1'b1);
            exp_q.push_back(cw(rn, rm, rd, FS_SUB, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
            m_flags = o[67:64];
            done_q.push_back({8'd1, 1'b0, m_flags});
`endif
        end else begin
            done_q.push_back({8'd0, 1'b1, m_flags});
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clock) begin : monitor
        logic [12:0] e;
        if (mon_en) begin
            if (bus.busy && !bus.done) begin
                check("tri_excl", 128'(bus.triSelBtoD & bus.triSelFtoD), 128'd0);
                check("ready_busy", 128'(bus.cmd_ready), 128'd0);
                if (exp_q.size() == 0) begin
                    check("exec_extra", 128'(dut_cw), 128'd0);
                    if (dut_cw == '0) begin
                        errors++;
                        $display("FAIL exec_extra: got unexpected EXEC cycle expected none (cycle %0d)", cyc);
                    end
                end else begin
                    check("exec_cw", 128'(dut_cw), 128'(exp_q.pop_front()));
                end
            end else begin
                check("idle_cw", 128'(dut_cw), 128'd0);
                if (bus.done) begin
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_extra: got done=1 expected no completion (cycle %0d)", cyc);
                    end else begin
                        e = done_q.pop_front();
                        check("done_err", 128'(bus.err), 128'(e[4]));
                        check("flags", 128'(bus.flags), 128'(e[3:0]));
                        check("latency", 128'(cyc - acc_cyc), 128'(e[12:5]));
                        check("exec_count", 128'(exp_q.size()), 128'd0);
                    end
                end else begin
                    check("err_idle", 128'(bus.err), 128'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------ driver
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [63:0] imm, input logic [5:0] sh);
        int t;
        t = 0;
        @(negedge clock);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 200 cycles");
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rn    = rn;
        bus.cmd_rm    = rm;
        bus.cmd_imm   = imm;
        bus.cmd_shamt = sh;
        model_cmd(op, rd, rn, rm, imm, sh);
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        // Garbage on the command inputs while busy must not matter.
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'($urandom);
        bus.cmd_rd    = 5'($urandom);
        bus.cmd_rn    = 5'($urandom);
        bus.cmd_rm    = 5'($urandom);
        bus.cmd_imm   = {$urandom, $urandom};
        bus.cmd_shamt = 6'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(posedge clock);
            #2;
            t++;
        end while ((bus.busy || exp_q.size() != 0 || done_q.size() != 0) && t < 300);
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy=%0b pending=%0d expected idle", bus.busy, done_q.size());
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        int w0;
        logic [3:0]  op;
        logic [5:0]  sh;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rn    = '0;
        bus.cmd_rm    = '0;
        bus.cmd_imm   = '0;
        bus.cmd_shamt = '0;
        for (int i = 0; i < 32; i++) m_x[i] = 64'd0;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_ready", 128'(bus.cmd_ready), 128'd1);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_err", 128'(bus.err), 128'd0);
        check("rst_flags", 128'(bus.flags), 128'd0);
        check("rst_cw", 128'(dut_cw), 128'd0);
        check("rst_state", 128'(bus.state_dbg), 128'd0);
        mon_en = 1'b1;

        // Give every register a known value through the sequencer itself.
        for (int i = 0; i < 31; i++) issue(4'd5, 5'(i), 5'd31, 5'($urandom), {$urandom, $urandom}, 6'd0);
        issue(4'd5, 5'd1, 5'd31, 5'd0, 64'd5, 6'd0);
        issue(4'd5, 5'd2, 5'd31, 5'd0, 64'd3, 6'd0);

        issue(4'd0, 5'd3, 5'd1, 5'd2, 64'd0, 6'd0);
        drain();
        check("add_x3", xreg[3], 128'd8);

        issue(4'd6, 5'd4, 5'd1, 5'd9, 64'd5, 6'd0);
        drain();
        check("subi_x4", xreg[4], 128'd0);
        check("subi_flags", 128'(bus.flags), 128'(4'b0101));

        issue(4'd8, 5'd5, 5'd1, 5'd0, 64'd0, 6'd4);
        drain();
        check("lsl4_x5", xreg[5], 128'd80);

        issue(4'd8, 5'd5, 5'd1, 5'd0, 64'd0, 6'd0);
        drain();
        check("lsl0_x5", xreg[5], 128'd5);

        w0 = wr_cnt;
        issue(4'd0, 5'd31, 5'd1, 5'd2, 64'd0, 6'd0);
        drain();
        check("rd31_writes", 128'(wr_cnt - w0), 128'd0);

        w0 = wr_cnt;
        issue(4'd12, 5'd3, 5'd1, 5'd2, 64'd0, 6'd0);
        drain();
        check("illegal_writes", 128'(wr_cnt - w0), 128'd0);
        check("illegal_x3", xreg[3], 128'd8);

        w0 = wr_cnt;
        issue(4'd9, 5'd7, 5'd1, 5'd1, 64'd0, 6'd0);
        drain();
        check("cmp_writes", 128'(wr_cnt - w0), 128'd0);
`ifdef DATAPATH_SEQ_CMP_EN
        check("cmp_zero", 128'(bus.flags[0]), 128'd1);
`endif

        // Reset during the second LSL iteration: two writes land, then IDLE.
        issue(4'd8, 5'd6, 5'd1, 5'd0, 64'd0, 6'd6);
        w0 = wr_cnt;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        done_q.delete();
        m_flags = 4'd0;
        m_x[6]  = m_x[1] << 2;
        check("mid_rst_busy", 128'(bus.busy), 128'd0);
        check("mid_rst_ready", 128'(bus.cmd_ready), 128'd1);
        check("mid_rst_w", 128'(bus.W), 128'd0);
        check("mid_rst_flags", 128'(bus.flags), 128'd0);
        check("mid_rst_writes", 128'(wr_cnt - w0), 128'd2);
        check("mid_rst_x6", xreg[6], 128'd20);
        repeat (5) @(posedge clock);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(9, 15));
            else                           op = 4'($urandom_range(0, 8));
            sh = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 9));
            issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom}, sh);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clock);
        end
        drain();
        for (int i = 0; i < 31; i++) check("final_xreg", xreg[i], m_x[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
